// File: rtl/kv_op_controller.sv
// -----------------------------------------------------------------------------
// kv_op_controller
//
// Single-outstanding key-value operation sequencer. It accepts one READ,
// UPSERT, DELETE or CLEAR request at a time, drives the one-hot entry-array
// strobes and returns a status code on a valid/ready response channel.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready request handshake, req_op = operation code
//   used                entry-occupied flags from the array
//   hit, hit_idx        key comparator result (one-hot, lowest bit wins)
//   mem_idx             target entries for the current strobe
//   mem_select          read/compare strobe
//   mem_write           write strobe
//   mem_delete          invalidate strobe
//   rsp_valid/rsp_ready response handshake, rsp_succ/rsp_code = status
//   occupancy           registered popcount of used
//   stat_hits/misses    saturating lookup statistics
//
// Build option
//   KV_CTRL_STATS_EN    when defined, stat_hits/stat_misses count EXEC
//                       outcomes; otherwise both are tied to zero.
// -----------------------------------------------------------------------------
module kv_op_controller #(
  parameter int NUM_ENTRIES = 16,
  parameter int LOOKUP_LAT  = 1,
  parameter int STAT_W      = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [2:0]                         req_op,
  input  logic [NUM_ENTRIES-1:0]             used,
  input  logic                               hit,
  input  logic [NUM_ENTRIES-1:0]             hit_idx,
  output logic [NUM_ENTRIES-1:0]             mem_idx,
  output logic                               mem_select,
  output logic                               mem_write,
  output logic                               mem_delete,
  output logic                               rsp_valid,
  input  logic                               rsp_ready,
  output logic                               rsp_succ,
  output logic [1:0]                         rsp_code,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   occupancy,
  output logic [STAT_W-1:0]                  stat_hits,
  output logic [STAT_W-1:0]                  stat_misses
);

  // state  | meaning
  // IDLE   | ready for a request
  // LOOKUP | key compare in flight, LOOKUP_LAT cycles
  // EXEC   | one-cycle action on the lookup result
  // CLEAR  | one-cycle invalidate of every used entry
  // RESP   | holding the response until rsp_ready
  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_EXEC,
    S_CLEAR,
    S_RESP
  } state_t;

  localparam int OCC_W = $clog2(NUM_ENTRIES + 1);
  localparam int CNT_W = (LOOKUP_LAT > 1) ? $clog2(LOOKUP_LAT) : 1;

  localparam logic [2:0] OP_NOP    = 3'd0;
  localparam logic [2:0] OP_READ   = 3'd1;
  localparam logic [2:0] OP_UPSERT = 3'd2;
  localparam logic [2:0] OP_DELETE = 3'd3;
  localparam logic [2:0] OP_CLEAR  = 3'd4;

  localparam logic [1:0] RC_OK    = 2'd0;
  localparam logic [1:0] RC_MISS  = 2'd1;
  localparam logic [1:0] RC_FULL  = 2'd2;
  localparam logic [1:0] RC_BADOP = 2'd3;

  localparam logic [NUM_ENTRIES-1:0] ONE = NUM_ENTRIES'(1);

  state_t                   state_q;
  logic [2:0]               op_q;
  logic [CNT_W-1:0]         cnt_q;
  logic                     hit_q;
  logic [NUM_ENTRIES-1:0]   hit_idx_q;
  logic                     req_ready_q;
  logic                     rsp_valid_q;
  logic                     rsp_succ_q;
  logic [1:0]               rsp_code_q;
  logic [OCC_W-1:0]         occ_q;
  logic [OCC_W-1:0]         occ_d;

  logic [NUM_ENTRIES-1:0]   hit_low;
  logic [NUM_ENTRIES-1:0]   free_low;
  logic                     full;
  logic [1:0]               exec_code;

  // x & -x isolates the lowest set bit; ~used & (used+1) the lowest clear bit.
  assign hit_low  = hit_idx & (~hit_idx + ONE);
  assign free_low = ~used & (used + ONE);
  assign full     = &used;

  always_comb begin
    mem_select = 1'b0;
    mem_write  = 1'b0;
    mem_delete = 1'b0;
    mem_idx    = '0;
    exec_code  = RC_OK;
    case (state_q)
      S_LOOKUP: mem_select = 1'b1;
      S_EXEC: begin
        case (op_q)
          OP_READ: begin
            if (hit_q) begin
              mem_select = 1'b1;
              mem_idx    = hit_idx_q;
            end else begin
              exec_code = RC_MISS;
            end
          end
          OP_UPSERT: begin
            if (hit_q) begin
              mem_write = 1'b1;
              mem_idx   = hit_idx_q;
            end else if (full) begin
              exec_code = RC_FULL;
            end else begin
              mem_write = 1'b1;
              mem_idx   = free_low;
            end
          end
          OP_DELETE: begin
            if (hit_q) begin
              mem_delete = 1'b1;
              mem_idx    = hit_idx_q;
            end else begin
              exec_code = RC_MISS;
            end
          end
          default: exec_code = RC_BADOP;
        endcase
      end
      S_CLEAR: begin
        mem_delete = 1'b1;
        mem_idx    = used;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NOP;
      cnt_q       <= '0;
      hit_q       <= 1'b0;
      hit_idx_q   <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_succ_q  <= 1'b0;
      rsp_code_q  <= RC_OK;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            op_q        <= req_op;
            req_ready_q <= 1'b0;
            case (req_op)
              OP_READ, OP_UPSERT, OP_DELETE: begin
                state_q <= S_LOOKUP;
                cnt_q   <= CNT_W'(LOOKUP_LAT - 1);
              end
              OP_CLEAR: state_q <= S_CLEAR;
              default: begin
                state_q     <= S_RESP;
                rsp_valid_q <= 1'b1;
                rsp_succ_q  <= 1'b0;
                rsp_code_q  <= RC_BADOP;
              end
            endcase
          end
        end
        S_LOOKUP: begin
          if (cnt_q == '0) begin
            // A hit flag with an empty index vector is treated as a miss.
            hit_q     <= hit & (|hit_idx);
            hit_idx_q <= hit_low;
            state_q   <= S_EXEC;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_EXEC: begin
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_succ_q  <= (exec_code == RC_OK);
          rsp_code_q  <= exec_code;
        end
        S_CLEAR: begin
          state_q     <= S_RESP;
          rsp_valid_q <= 1'b1;
          rsp_succ_q  <= 1'b1;
          rsp_code_q  <= RC_OK;
        end
        S_RESP: begin
          if (rsp_ready) begin
            state_q     <= S_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      occ_d = occ_d + OCC_W'(used[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

`ifdef KV_CTRL_STATS_EN
  logic [STAT_W-1:0] stat_hits_q;
  logic [STAT_W-1:0] stat_misses_q;

  // FULL is a lookup miss, so it lands in stat_misses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_hits_q   <= '0;
      stat_misses_q <= '0;
    end else if (state_q == S_EXEC) begin
      if (hit_q) begin
        if (stat_hits_q != '1) stat_hits_q <= stat_hits_q + STAT_W'(1);
      end else begin
        if (stat_misses_q != '1) stat_misses_q <= stat_misses_q + STAT_W'(1);
      end
    end
  end

  assign stat_hits   = stat_hits_q;
  assign stat_misses = stat_misses_q;
`else
  assign stat_hits   = '0;
  assign stat_misses = '0;
`endif

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_succ  = rsp_succ_q;
  assign rsp_code  = rsp_code_q;
  assign occupancy = occ_q;

endmodule

// File: tb/tb_kv_op_controller.sv
// Scoreboard bench for kv_op_controller: the driver issues operations and
// queues the expected strobes and responses; a negedge monitor pops and
// compares whatever the DUT presents.
module tb_kv_op_controller;

  localparam int N   = 16;
  localparam int LAT = 3;
  localparam int SW  = 2;
  localparam int OW  = $clog2(N + 1);

  localparam logic [2:0] OP_READ   = 3'd1;
  localparam logic [2:0] OP_UPSERT = 3'd2;
  localparam logic [2:0] OP_DELETE = 3'd3;
  localparam logic [2:0] OP_CLEAR  = 3'd4;

  localparam int K_SEL = 1;
  localparam int K_WR  = 2;
  localparam int K_DEL = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           req_valid = 1'b0;
  logic           req_ready;
  logic [2:0]     req_op = 3'd0;
  logic [N-1:0]   used = '0;
  logic           hit = 1'b0;
  logic [N-1:0]   hit_idx = '0;
  logic [N-1:0]   mem_idx;
  logic           mem_select, mem_write, mem_delete;
  logic           rsp_valid;
  logic           rsp_ready = 1'b0;
  logic           rsp_succ;
  logic [1:0]     rsp_code;
  logic [OW-1:0]  occupancy;
  logic [SW-1:0]  stat_hits, stat_misses;

  always #5 clk = ~clk;

  kv_op_controller #(.NUM_ENTRIES(N), .LOOKUP_LAT(LAT), .STAT_W(SW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .used(used), .hit(hit), .hit_idx(hit_idx),
    .mem_idx(mem_idx), .mem_select(mem_select), .mem_write(mem_write),
    .mem_delete(mem_delete),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_succ(rsp_succ),
    .rsp_code(rsp_code), .occupancy(occupancy),
    .stat_hits(stat_hits), .stat_misses(stat_misses)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {int kind; logic [N-1:0] idx; int cyc;} strb_t;
  typedef struct {logic [1:0] code; logic succ; int cyc;} rsp_t;
  strb_t sq[$];
  rsp_t  rq[$];
  int m_hits = 0;
  int m_misses = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int exp_stat(input int m);
`ifdef KV_CTRL_STATS_EN
    return (m > (2**SW - 1)) ? (2**SW - 1) : m;
`else
    return 0;
`endif
  endfunction

  // ---------------------------------------------------------------- monitor
  always @(posedge clk) cyc <= cyc + 1;

  logic         hs_edge = 1'b0;
  logic [N-1:0] used_edge = '0;
  int           edges_ok = 0;
  always @(posedge clk) begin
    hs_edge   <= rsp_valid & rsp_ready;
    used_edge <= used;
    edges_ok  <= rst ? 0 : edges_ok + 1;
  end

  logic  prev_valid = 1'b0;
  rsp_t  cur_rsp;
  strb_t cur_s;
  int    m_ns, m_kind;

  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      while (sq.size() > 0 && sq[0].cyc < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL strobe_missing: no strobe observed, required kind %0d idx %0h at cycle %0d",
                 sq[0].kind, sq[0].idx, sq[0].cyc);
        void'(sq.pop_front());
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        n_chk++; n_fail++;
        $display("FAIL rsp_missing: no response observed, required code %0d at cycle %0d",
                 rq[0].code, rq[0].cyc);
        void'(rq.pop_front());
      end
      m_ns = int'(mem_select) + int'(mem_write) + int'(mem_delete);
      if (m_ns > 1) begin
        chk("one_strobe", m_ns, 1);
      end else if (m_ns == 1) begin
        m_kind = mem_select ? K_SEL : (mem_write ? K_WR : K_DEL);
        if (sq.size() == 0) begin
          chk("strobe_unexpected", m_kind, 0);
        end else begin
          cur_s = sq.pop_front();
          chk("strobe_kind", m_kind, cur_s.kind);
          chk("strobe_idx", mem_idx, cur_s.idx);
          chk("strobe_cycle", cyc, cur_s.cyc);
        end
      end else if (mem_idx != '0) begin
        chk("idx_without_strobe", mem_idx, 0);
      end

      if (rsp_valid) begin
        chk("busy_req_ready", req_ready, 0);
        if (!prev_valid) begin
          if (rq.size() == 0) begin
            chk("rsp_unexpected", rsp_valid, 0);
            cur_rsp.code = rsp_code; cur_rsp.succ = rsp_succ; cur_rsp.cyc = cyc;
          end else begin
            cur_rsp = rq.pop_front();
            chk("rsp_code", rsp_code, cur_rsp.code);
            chk("rsp_succ", rsp_succ, cur_rsp.succ);
            chk("rsp_cycle", cyc, cur_rsp.cyc);
          end
        end else begin
          if (hs_edge) chk("valid_after_hs", rsp_valid, 0);
          chk("rsp_hold_code", rsp_code, cur_rsp.code);
          chk("rsp_hold_succ", rsp_succ, cur_rsp.succ);
        end
      end else if (prev_valid) begin
        chk("drop_without_hs", hs_edge, 1);
      end

      if (edges_ok >= 1) chk("occupancy", occupancy, $countones(used_edge));
      prev_valid = rsp_valid;
    end
  end

  // ----------------------------------------------------------------- driver
  // Starts and ends at a negedge. abort_at>0 pulses rst during that cycle.
  task automatic do_op(input logic [2:0] op, input logic [N-1:0] u, input logic h,
                       input logic [N-1:0] hi, input bit pre, input int hold,
                       input int abort_at);
    int base, t, hcnt, ix;
    bit seen, done, eff, lk;
    strb_t s;
    rsp_t r;
    t = 0;
    while (!req_ready && t < 20) begin @(negedge clk); t++; end
    if (!req_ready) begin chk("req_ready_timeout", req_ready, 1); return; end

    used = u; hit = h; hit_idx = hi; req_op = op; req_valid = 1'b1; rsp_ready = pre;
    base = cyc;

    // reference model
    eff = h && (hi != '0);
    lk  = (op == OP_READ) || (op == OP_UPSERT) || (op == OP_DELETE);
    r.code = 2'd0; r.succ = 1'b1; r.cyc = base + LAT + 2;
    s.kind = 0; s.idx = '0; s.cyc = base + LAT + 1;
    if (lk) begin
      for (int k = 1; k <= LAT; k++) begin
        strb_t l;
        l.kind = K_SEL; l.idx = '0; l.cyc = base + k;
        sq.push_back(l);
      end
      ix = eff ? lowest(hi) : -1;
      if (eff) s.idx[ix] = 1'b1;
      if (eff) m_hits++; else m_misses++;
    end
    case (op)
      OP_READ:   if (eff) s.kind = K_SEL; else r.code = 2'd1;
      OP_DELETE: if (eff) s.kind = K_DEL; else r.code = 2'd1;
      OP_UPSERT: begin
        if (eff) s.kind = K_WR;
        else if (lowest(~u) >= 0) begin s.kind = K_WR; s.idx[lowest(~u)] = 1'b1; end
        else r.code = 2'd2;
      end
      OP_CLEAR: begin
        s.kind = K_DEL; s.idx = u; s.cyc = base + 1; r.cyc = base + 2;
      end
      default: begin r.code = 2'd3; r.cyc = base + 1; end
    endcase
    r.succ = (r.code == 2'd0);
    if (s.kind != 0) sq.push_back(s);
    rq.push_back(r);

    if (abort_at > 0) begin
      @(negedge clk); req_valid = 1'b0;
      repeat (abort_at - 1) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      sq.delete(); rq.delete(); m_hits = 0; m_misses = 0;
      chk("abort_req_ready", req_ready, 1);
      chk("abort_strobes", {mem_select, mem_write, mem_delete}, 0);
      chk("abort_mem_idx", mem_idx, 0);
      chk("abort_rsp", {rsp_valid, rsp_succ, rsp_code}, 0);
      chk("abort_occupancy", occupancy, 0);
      chk("abort_stats", {stat_hits, stat_misses}, 0);
      @(negedge clk); @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      return;
    end

    seen = 0; done = 0; t = 0; hcnt = 0;
    while (!done) begin
      @(negedge clk); t++;
      if (!seen && rsp_valid) begin seen = 1; req_valid = 1'b0; hcnt = hold; end
      if (!seen) begin
        if (t > LAT + 4) begin
          chk("rsp_timeout", rsp_valid, 1);
          req_valid = 1'b0; rsp_ready = 1'b0;
          return;
        end
        req_valid = 1'($urandom_range(0, 1));
        req_op    = 3'($urandom_range(0, 7));
      end else if (pre || hcnt == 0) begin
        rsp_ready = 1'b1; req_valid = 1'b0; done = 1;
      end else begin
        rsp_ready = 1'b0; hcnt--;
        req_valid = 1'($urandom_range(0, 1));
        req_op    = 3'($urandom_range(0, 7));
      end
    end
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("ready_after_rsp", req_ready, 1);
    chk("stat_hits", stat_hits, exp_stat(m_hits));
    chk("stat_misses", stat_misses, exp_stat(m_misses));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion by t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]   op;
    logic [N-1:0] u, hi;
    logic         h;
    repeat (2) @(negedge clk);
    chk("rst_strobes", {mem_select, mem_write, mem_delete}, 0);
    chk("rst_mem_idx", mem_idx, 0);
    chk("rst_rsp", {rsp_valid, rsp_succ, rsp_code}, 0);
    chk("rst_occ_stats", {occupancy, stat_hits, stat_misses}, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", req_ready, 1);

    do_op(OP_READ,   16'h0000, 1'b1, 16'h0004, 1'b1, 0, 0);
    do_op(OP_UPSERT, 16'h00FF, 1'b0, 16'h0000, 1'b0, 1, 0);
    do_op(OP_UPSERT, 16'hFFFF, 1'b0, 16'h0000, 1'b1, 0, 0);
    do_op(OP_DELETE, 16'h0F0F, 1'b0, 16'h0000, 1'b0, 2, 0);
    do_op(OP_CLEAR,  16'h0A05, 1'b0, 16'h0000, 1'b1, 0, 0);
    chk("occ_before_clear_done", occupancy, 4);
    used = '0;
    @(negedge clk); @(negedge clk);
    chk("occ_after_clear", occupancy, 0);
    do_op(3'd6,      16'h0000, 1'b0, 16'h0000, 1'b0, 5, 0);
    do_op(OP_READ,   16'h1234, 1'b1, 16'h0A30, 1'b1, 0, 0);
    do_op(OP_READ,   16'h1234, 1'b1, 16'h0000, 1'b0, 0, 0);
    do_op(OP_DELETE, 16'h00F0, 1'b1, 16'h0040, 1'b1, 0, 0);
    do_op(OP_CLEAR,  16'h0000, 1'b0, 16'h0000, 1'b0, 0, 0);
    do_op(OP_READ,   16'h0003, 1'b1, 16'h0002, 1'b0, 0, 2);
    for (int i = 0; i < 5; i++) do_op(OP_READ, 16'h0003, 1'b1, 16'h0001, 1'b1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op = OP_READ;
        3, 4, 5: op = OP_UPSERT;
        6, 7:    op = OP_DELETE;
        8:       op = OP_CLEAR;
        default: begin
          case ($urandom_range(0, 3))
            0:       op = 3'd0;
            1:       op = 3'd5;
            2:       op = 3'd6;
            default: op = 3'd7;
          endcase
        end
      endcase
      case ($urandom_range(0, 3))
        0:       u = '0;
        1:       u = '1;
        default: u = N'($urandom);
      endcase
      h = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       hi = '0;
        1:       hi = N'($urandom);
        default: begin hi = '0; hi[$urandom_range(0, N - 1)] = 1'b1; end
      endcase
      do_op(op, u, h, hi, 1'($urandom_range(0, 1)), $urandom_range(0, 3), 0);
    end

    repeat (4) @(negedge clk);
    chk("strobe_queue_drained", sq.size(), 0);
    chk("rsp_queue_drained", rq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/kv_op_controller.md
# kv_op_controller

Parametrised successor to the single-request cache controller. It accepts one key-value operation at a time over a valid/ready request channel and drives the one-hot memory-array control signals. Operations are READ, UPSERT, DELETE and a new CLEAR (flush). Each result is returned on a valid/ready response channel with a status code. The block sits between the host interface front-end and the entry array / key comparator, and replaces the per-operation sub-FSM arrangement with one unified sequencer.

## Interface
Parameters:
- NUM_ENTRIES, 16: number of cache entries; width of all one-hot vectors; ≥2.
- LOOKUP_LAT, 1: cycles from lookup start until `hit`/`hit_idx` are valid; ≥1.
- STAT_W, 16: width of statistics counters (only used with KV_CTRL_STATS_EN).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  3  0=NOP, 1=READ, 2=UPSERT, 3=DELETE, 4=CLEAR, 5-7 reserved.
- used  in  NUM_ENTRIES  entry-occupied flags from the array.
- hit  in  1  key comparator match.
- hit_idx  in  NUM_ENTRIES  matching entry, one-hot.
- mem_idx  out  NUM_ENTRIES  target entries.
- mem_select  out  1  read/compare strobe.
- mem_write  out  1  write strobe.
- mem_delete  out  1  invalidate strobe.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumer ready.
- rsp_succ  out  1  operation succeeded.
- rsp_code  out  2  0=OK, 1=MISS, 2=FULL, 3=BADOP.
- occupancy  out  $clog2(NUM_ENTRIES+1)  registered popcount of `used`.
- stat_hits, stat_misses  out  STAT_W each  saturating counters.

## Operation
States: IDLE, LOOKUP, EXEC, CLEAR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch req_op.
  - READ/UPSERT/DELETE → LOOKUP.
  - CLEAR → CLEAR.
  - NOP or reserved → RESP with code BADOP, succ=0.
- LOOKUP: mem_select=1, mem_idx=0. A counter runs LOOKUP_LAT cycles; on its last cycle `hit` and `hit_idx` are sampled into registers → EXEC.
- EXEC (one cycle), by operation:
  - READ hit: mem_select=1, mem_idx=hit_idx, OK.
  - READ miss: MISS, no strobe.
  - UPSERT hit: mem_write=1, mem_idx=hit_idx, OK.
  - UPSERT miss: mem_write=1, mem_idx=lowest-index clear bit of `used`, OK. If `used` is all ones, no strobe and code FULL.
  - DELETE hit: mem_delete=1, mem_idx=hit_idx, OK.
  - DELETE miss: MISS.
  - Then → RESP.
- CLEAR (one cycle): mem_delete=1, mem_idx=`used`, OK → RESP. An empty array still returns OK.
- RESP: rsp_valid=1 with stable rsp_succ/rsp_code until rsp_ready=1 → IDLE. req_ready=0.
- Outside the cases above, all strobes and mem_idx are 0. At most one strobe is asserted per cycle.
- If hit=1 but hit_idx has several bits set, the lowest set bit is used. If hit=1 with hit_idx=0, the controller treats it as a miss.
- rsp_succ = (rsp_code==OK).

## Timing
- Reset values:
  - State IDLE.
  - req_ready=1 from the first cycle after reset deasserts.
  - All strobes, mem_idx, rsp_valid, rsp_succ, rsp_code, occupancy and stats are 0.
- Request accepted at cycle 0 (edge where req_valid & req_ready):
  - LOOKUP occupies cycles 1..LOOKUP_LAT.
  - EXEC is at cycle LOOKUP_LAT+1.
  - rsp_valid first asserts at cycle LOOKUP_LAT+2.
- CLEAR: strobe at cycle 1; rsp_valid at cycle 2.
- BADOP: rsp_valid at cycle 1.
- If rsp_ready is already high when rsp_valid rises, the handshake completes that cycle. The next request can be accepted one cycle later (IDLE). Back-to-back throughput is one op per LOOKUP_LAT+3 cycles.
- `used` is sampled in EXEC/CLEAR, not at accept.
- occupancy updates one cycle after `used` changes.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values; the pending response is discarded.

## Configuration
- KV_CTRL_STATS_EN defined:
  - stat_hits increments on every EXEC with a sampled hit.
  - stat_misses increments on every EXEC with a miss, including FULL.
  - Both saturate at 2^STAT_W−1 and are cleared only by rst.
- Not defined: no counter logic; stat_hits and stat_misses are tied to 0.

## Test plan
- Reset, then READ with hit=1, hit_idx=0x0004, LOOKUP_LAT=1 → cycle 2 mem_select=1, mem_idx=0x0004; cycle 3 rsp_valid=1, rsp_code=0, rsp_succ=1.
- UPSERT miss with used=0x00FF → mem_write=1, mem_idx=0x0100, code OK. Repeat with used=0xFFFF → no strobe, code FULL (2), rsp_succ=0.
- DELETE miss → no strobe, code MISS (1). CLEAR with used=0x0A05 → one-cycle mem_delete=1, mem_idx=0x0A05, OK; occupancy goes from 4 to 0 after used clears.
- req_op=6 → rsp_valid at cycle 1, code BADOP (3). Hold rsp_ready=0 for 5 cycles → response stable, req_ready=0, a new req_valid is ignored.
- Assert rst during LOOKUP (LOOKUP_LAT=3) → next cycle all outputs 0, req_ready=1, and no response is ever produced for the aborted op.
- With KV_CTRL_STATS_EN and STAT_W=2: 5 READ hits → stat_hits saturates at 3, stat_misses=0. Without the macro → both remain 0.
